// File: rtl/simmem_pkg.sv
// Shared widths, channel payload types, response codes and FSM state types
// for the simulated-memory responder.
package simmem_pkg;

  localparam int IDWidth       = 4;
  localparam int AddrWidth     = 16;
  localparam int DataWidth     = 32;
  localparam int BurstLenWidth = 8;

  localparam logic [1:0] RespOkay   = 2'b00;
  localparam logic [1:0] RespSlvErr = 2'b10;

  typedef struct packed {
    logic [IDWidth-1:0]       id;
    logic [AddrWidth-1:0]     addr;
    logic [BurstLenWidth-1:0] burst_len;
  } raddr_req_t;

  typedef struct packed {
    logic [IDWidth-1:0]       id;
    logic [AddrWidth-1:0]     addr;
    logic [BurstLenWidth-1:0] burst_len;
  } waddr_req_t;

  typedef struct packed {
    logic [DataWidth-1:0] data;
    logic                 last;
  } wdata_req_t;

  typedef struct packed {
    logic [IDWidth-1:0]   id;
    logic [DataWidth-1:0] data;
    logic [1:0]           rsp;
    logic                 last;
  } rdata_t;

  typedef struct packed {
    logic [IDWidth-1:0] id;
    logic [1:0]         rsp;
  } wresp_t;

  typedef enum logic {
    R_IDLE,
    R_BURST
  } rd_state_e;

  typedef enum logic [1:0] {
    W_IDLE,
    W_DATA,
    W_RESP
  } wr_state_e;

endpackage

// File: rtl/simmem_resp_mem.sv
// Word-addressed storage: one asynchronous read port, one synchronous write
// port, cleared to zero by reset. MemDepth must be a power of two >= 2.
module simmem_resp_mem
  import simmem_pkg::*;
#(
  parameter int MemDepth = 16
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic [$clog2(MemDepth)-1:0] raddr_i,
  output logic [DataWidth-1:0]        rdata_o,
  input  logic                        we_i,
  input  logic [$clog2(MemDepth)-1:0] waddr_i,
  input  logic [DataWidth-1:0]        wdata_i
);

  logic [DataWidth-1:0] mem_q [MemDepth];

  // Storage array with asynchronous clear and a single write port.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_q <= '{default: '0};
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/simmem_mem_responder.sv
// Memory-side responder: terminates raddr/waddr/wdata, returns rdata/wresp
// from a small storage array. Read and write channels run independently.
//
// state   | meaning
// R_IDLE  | waiting for a read request (raddr_ready_o=1)
// R_BURST | presenting a registered read beat (rdata_valid_o=1)
// W_IDLE  | waiting for a write address (waddr_ready_o=1)
// W_DATA  | accepting write beats until one with last=1
// W_RESP  | presenting the write response (wresp_valid_o=1)
module simmem_mem_responder
  import simmem_pkg::*;
#(
  parameter int MemDepth = 16,
  parameter bit ErrOnOob = 1'b1
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       raddr_valid_i,
  output logic       raddr_ready_o,
  input  raddr_req_t raddr_req_i,
  input  logic       waddr_valid_i,
  output logic       waddr_ready_o,
  input  waddr_req_t waddr_req_i,
  input  logic       wdata_valid_i,
  output logic       wdata_ready_o,
  input  wdata_req_t wdata_req_i,
  output logic       rdata_valid_o,
  input  logic       rdata_ready_i,
  output rdata_t     rdata_o,
  output logic       wresp_valid_o,
  input  logic       wresp_ready_i,
  output wresp_t     wresp_o
);

  localparam int IdxWidth = $clog2(MemDepth);

  function automatic logic is_oob(input logic [AddrWidth-1:0] a);
    return ErrOnOob && (32'(a) >= 32'(MemDepth));
  endfunction

  rd_state_e                r_state_q, r_state_d;
  logic [IDWidth-1:0]       r_id_q, r_id_d;
  logic [AddrWidth-1:0]     r_addr_q, r_addr_d;
  logic [BurstLenWidth-1:0] r_beats_q, r_beats_d;
  rdata_t                   rdata_q, rdata_d;
  logic                     r_load;
  logic [DataWidth-1:0]     mem_rdata;

  wr_state_e                w_state_q, w_state_d;
  logic [IDWidth-1:0]       w_id_q, w_id_d;
  logic [AddrWidth-1:0]     w_addr_q, w_addr_d;
  logic [BurstLenWidth-1:0] w_len_q, w_len_d;
  logic [BurstLenWidth:0]   w_cnt_q, w_cnt_d;
  logic                     w_err_q, w_err_d;
  wresp_t                   wresp_q, wresp_d;
  logic                     mem_we;
  logic                     beat_err;

  // The read port always looks at the address being loaded this cycle, so a
  // beat captures the pre-write value when a write hits the same word.
  simmem_resp_mem #(
    .MemDepth(MemDepth)
  ) u_mem (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .raddr_i(r_addr_d[IdxWidth-1:0]),
    .rdata_o(mem_rdata),
    .we_i   (mem_we),
    .waddr_i(w_addr_q[IdxWidth-1:0]),
    .wdata_i(wdata_req_i.data)
  );

  // Read FSM next state, beat loading and handshake outputs.
  always_comb begin
    r_state_d     = r_state_q;
    r_id_d        = r_id_q;
    r_addr_d      = r_addr_q;
    r_beats_d     = r_beats_q;
    rdata_d       = rdata_q;
    r_load        = 1'b0;
    raddr_ready_o = 1'b0;
    rdata_valid_o = 1'b0;
    case (r_state_q)
      R_IDLE: begin
        raddr_ready_o = 1'b1;
        r_addr_d      = raddr_req_i.addr;
        if (raddr_valid_i) begin
          r_load    = 1'b1;
          r_id_d    = raddr_req_i.id;
          r_beats_d = raddr_req_i.burst_len;
          r_state_d = R_BURST;
        end
      end
      R_BURST: begin
        rdata_valid_o = 1'b1;
        if (rdata_ready_i) begin
          if (rdata_q.last) begin
            r_state_d = R_IDLE;
          end else begin
            r_load    = 1'b1;
            r_addr_d  = r_addr_q + 1'b1;
            r_beats_d = r_beats_q - 1'b1;
          end
        end
      end
      default: r_state_d = R_IDLE;
    endcase
    if (r_load) begin
      rdata_d.id   = r_id_d;
      rdata_d.data = is_oob(r_addr_d) ? '0 : mem_rdata;
      rdata_d.rsp  = is_oob(r_addr_d) ? RespSlvErr : RespOkay;
      rdata_d.last = (r_beats_d == '0);
    end
  end

  // Read FSM registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state_q <= R_IDLE;
      r_id_q    <= '0;
      r_addr_q  <= '0;
      r_beats_q <= '0;
      rdata_q   <= '0;
    end else begin
      r_state_q <= r_state_d;
      r_id_q    <= r_id_d;
      r_addr_q  <= r_addr_d;
      r_beats_q <= r_beats_d;
      rdata_q   <= rdata_d;
    end
  end

  // A beat is in error if out of range, past the declared length, or a
  // premature/late last.
  assign beat_err = is_oob(w_addr_q)
                  | (w_cnt_q > {1'b0, w_len_q})
                  | (wdata_req_i.last && (w_cnt_q != {1'b0, w_len_q}));

  // Write FSM next state, storage write enable and handshake outputs.
  always_comb begin
    w_state_d     = w_state_q;
    w_id_d        = w_id_q;
    w_addr_d      = w_addr_q;
    w_len_d       = w_len_q;
    w_cnt_d       = w_cnt_q;
    w_err_d       = w_err_q;
    wresp_d       = wresp_q;
    mem_we        = 1'b0;
    waddr_ready_o = 1'b0;
    wdata_ready_o = 1'b0;
    wresp_valid_o = 1'b0;
    case (w_state_q)
      W_IDLE: begin
        waddr_ready_o = 1'b1;
        if (waddr_valid_i) begin
          w_id_d    = waddr_req_i.id;
          w_addr_d  = waddr_req_i.addr;
          w_len_d   = waddr_req_i.burst_len;
          w_cnt_d   = '0;
          w_err_d   = 1'b0;
          w_state_d = W_DATA;
        end
      end
      W_DATA: begin
        wdata_ready_o = 1'b1;
        if (wdata_valid_i) begin
          mem_we   = !is_oob(w_addr_q);
          w_addr_d = w_addr_q + 1'b1;
          w_cnt_d  = w_cnt_q + 1'b1;
          w_err_d  = w_err_q | beat_err;
          if (wdata_req_i.last) begin
            wresp_d.id  = w_id_q;
            wresp_d.rsp = (w_err_q | beat_err) ? RespSlvErr : RespOkay;
            w_state_d   = W_RESP;
          end
        end
      end
      W_RESP: begin
        wresp_valid_o = 1'b1;
        if (wresp_ready_i) begin
          w_state_d = W_IDLE;
        end
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  // Write FSM registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      w_state_q <= W_IDLE;
      w_id_q    <= '0;
      w_addr_q  <= '0;
      w_len_q   <= '0;
      w_cnt_q   <= '0;
      w_err_q   <= 1'b0;
      wresp_q   <= '0;
    end else begin
      w_state_q <= w_state_d;
      w_id_q    <= w_id_d;
      w_addr_q  <= w_addr_d;
      w_len_q   <= w_len_d;
      w_cnt_q   <= w_cnt_d;
      w_err_q   <= w_err_d;
      wresp_q   <= wresp_d;
    end
  end

  assign rdata_o = rdata_q;
  assign wresp_o = wresp_q;

endmodule

// File: tb/tb_simmem_mem_responder.sv
// Directed bench for simmem_mem_responder: a table of write bursts with
// read-back, plus hand sequences for out-of-range, backpressure, collision
// and reset. A second instance with ErrOnOob=0 covers the wrap-around read.
module tb_simmem_mem_responder;
  import simmem_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       raddr_valid = 1'b0;
  raddr_req_t raddr_req = '0;
  logic       waddr_valid = 1'b0;
  waddr_req_t waddr_req = '0;
  logic       wdata_valid = 1'b0;
  wdata_req_t wdata_req = '0;
  logic       rdata_ready = 1'b0;
  logic       wresp_ready = 1'b0;

  logic   raddr_ready, waddr_ready, wdata_ready, rdata_valid, wresp_valid;
  rdata_t rdata;
  wresp_t wresp;
  logic   raddr_ready0, waddr_ready0, wdata_ready0, rdata_valid0, wresp_valid0;
  rdata_t rdata0;
  wresp_t wresp0;

  int n_chk = 0;
  int n_fail = 0;
  logic [31:0] exp_mem [16];

  always #5 clk = ~clk;

  simmem_mem_responder #(.MemDepth(16), .ErrOnOob(1'b1)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .raddr_valid_i(raddr_valid), .raddr_ready_o(raddr_ready), .raddr_req_i(raddr_req),
    .waddr_valid_i(waddr_valid), .waddr_ready_o(waddr_ready), .waddr_req_i(waddr_req),
    .wdata_valid_i(wdata_valid), .wdata_ready_o(wdata_ready), .wdata_req_i(wdata_req),
    .rdata_valid_o(rdata_valid), .rdata_ready_i(rdata_ready), .rdata_o(rdata),
    .wresp_valid_o(wresp_valid), .wresp_ready_i(wresp_ready), .wresp_o(wresp)
  );

  simmem_mem_responder #(.MemDepth(16), .ErrOnOob(1'b0)) dut0 (
    .clk_i(clk), .rst_ni(rst_n),
    .raddr_valid_i(raddr_valid), .raddr_ready_o(raddr_ready0), .raddr_req_i(raddr_req),
    .waddr_valid_i(waddr_valid), .waddr_ready_o(waddr_ready0), .waddr_req_i(waddr_req),
    .wdata_valid_i(wdata_valid), .wdata_ready_o(wdata_ready0), .wdata_req_i(wdata_req),
    .rdata_valid_o(rdata_valid0), .rdata_ready_i(rdata_ready), .rdata_o(rdata0),
    .wresp_valid_o(wresp_valid0), .wresp_ready_i(wresp_ready), .wresp_o(wresp0)
  );

  typedef struct {
    logic [3:0]  id;
    logic [15:0] addr;
    logic [7:0]  len;
    int          nbeats;
    logic [31:0] base;
    logic [1:0]  exp_rsp;
  } wvec_t;

  wvec_t tbl [5];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic do_write(input logic [3:0] t_id, input logic [15:0] t_addr,
                          input logic [7:0] t_len, input int nb, input logic [31:0] t_base,
                          input logic [1:0] exp_rsp, input bit stall);
    int n;
    logic [15:0] a;
    waddr_req.id = t_id;
    waddr_req.addr = t_addr;
    waddr_req.burst_len = t_len;
    waddr_valid = 1'b1;
    wresp_ready = 1'b0;
    n = 0;
    while (!waddr_ready && n < 50) begin @(posedge clk); #1; n++; end
    chk("waddr_ready", 64'(waddr_ready), 64'(1));
    @(posedge clk); #1;
    waddr_valid = 1'b0;
    for (int i = 0; i < nb; i++) begin
      wdata_req.data = t_base + 32'h11 * 32'(i);
      wdata_req.last = (i == nb - 1);
      wdata_valid = 1'b1;
      n = 0;
      while (!wdata_ready && n < 50) begin @(posedge clk); #1; n++; end
      chk("wdata_ready", 64'(wdata_ready), 64'(1));
      @(posedge clk); #1;
      a = t_addr + 16'(i);
      if (a < 16) exp_mem[a[3:0]] = wdata_req.data;
    end
    wdata_valid = 1'b0;
    chk("wresp_valid", 64'(wresp_valid), 64'(1));
    chk("wresp_id", 64'(wresp.id), 64'(t_id));
    chk("wresp_rsp", 64'(wresp.rsp), 64'(exp_rsp));
    if (stall) begin
      repeat (3) begin
        @(posedge clk); #1;
        chk("wresp_stall_valid", 64'(wresp_valid), 64'(1));
        chk("wresp_stall_rsp", 64'(wresp.rsp), 64'(exp_rsp));
      end
    end
    wresp_ready = 1'b1;
    @(posedge clk); #1;
    wresp_ready = 1'b0;
    chk("wresp_drop", 64'(wresp_valid), 64'(0));
  endtask

  task automatic do_read(input logic [3:0] t_id, input logic [15:0] t_addr,
                         input logic [7:0] t_len, input int stall_beat, input bit chk0);
    int n;
    logic [15:0] a;
    logic [31:0] ed;
    logic [1:0]  er;
    raddr_req.id = t_id;
    raddr_req.addr = t_addr;
    raddr_req.burst_len = t_len;
    raddr_valid = 1'b1;
    rdata_ready = 1'b1;
    n = 0;
    while (!raddr_ready && n < 50) begin @(posedge clk); #1; n++; end
    chk("raddr_ready", 64'(raddr_ready), 64'(1));
    @(posedge clk); #1;
    raddr_valid = 1'b0;
    for (int i = 0; i <= int'(t_len); i++) begin
      a  = t_addr + 16'(i);
      ed = (a < 16) ? exp_mem[a[3:0]] : 32'h0;
      er = (a < 16) ? RespOkay : RespSlvErr;
      chk("rdata_valid", 64'(rdata_valid), 64'(1));
      chk("rdata_id", 64'(rdata.id), 64'(t_id));
      chk("rdata_data", 64'(rdata.data), 64'(ed));
      chk("rdata_rsp", 64'(rdata.rsp), 64'(er));
      chk("rdata_last", 64'(rdata.last), 64'(i == int'(t_len)));
      if (chk0) begin
        chk("rdata0_data", 64'(rdata0.data), 64'(exp_mem[a[3:0]]));
        chk("rdata0_rsp", 64'(rdata0.rsp), 64'(RespOkay));
      end
      if (i == stall_beat) begin
        rdata_ready = 1'b0;
        repeat (3) begin
          @(posedge clk); #1;
          chk("rstall_valid", 64'(rdata_valid), 64'(1));
          chk("rstall_data", 64'(rdata.data), 64'(ed));
          chk("rstall_last", 64'(rdata.last), 64'(i == int'(t_len)));
        end
        rdata_ready = 1'b1;
      end
      @(posedge clk); #1;
    end
    chk("rdata_bubble", 64'(rdata_valid), 64'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    for (int i = 0; i < 16; i++) exp_mem[i] = '0;
    tbl[0] = '{4'h3, 16'd2,  8'd1, 2, 32'h0000_00AA, RespOkay};
    tbl[1] = '{4'h1, 16'd6,  8'd2, 2, 32'h0000_0600, RespSlvErr};
    tbl[2] = '{4'h2, 16'd9,  8'd0, 2, 32'h0000_0900, RespSlvErr};
    tbl[3] = '{4'h7, 16'd12, 8'd3, 4, 32'h0000_0C00, RespOkay};
    tbl[4] = '{4'hF, 16'd0,  8'd0, 1, 32'h0000_1234, RespOkay};

    #2 rst_n = 1'b0;
    #10;
    chk("rst_raddr_ready", 64'(raddr_ready), 64'(1));
    chk("rst_waddr_ready", 64'(waddr_ready), 64'(1));
    chk("rst_wdata_ready", 64'(wdata_ready), 64'(0));
    chk("rst_rdata_valid", 64'(rdata_valid), 64'(0));
    chk("rst_wresp_valid", 64'(wresp_valid), 64'(0));
    chk("rst_rdata", 64'(rdata), 64'(0));
    chk("rst_wresp", 64'(wresp), 64'(0));
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    for (int v = 0; v < 5; v++) begin
      do_write(tbl[v].id, tbl[v].addr, tbl[v].len, tbl[v].nbeats, tbl[v].base, tbl[v].exp_rsp, 1'b0);
      do_read(tbl[v].id ^ 4'h6, tbl[v].addr, 8'(tbl[v].nbeats - 1), -1, 1'b0);
    end

    // Beat 1 at address 16: SLVERR/0 with range check, word 0 without.
    do_read(4'hA, 16'd15, 8'd1, -1, 1'b1);

    // Out-of-range write beat is dropped; in-range beat still lands.
    do_write(4'h4, 16'd15, 8'd1, 2, 32'h0000_0F00, RespSlvErr, 1'b0);
    do_read(4'h4, 16'd15, 8'd0, -1, 1'b0);

    // wdata ahead of waddr is held off, then accepted; wresp backpressure.
    wdata_req.data = 32'h77;
    wdata_req.last = 1'b1;
    wdata_valid = 1'b1;
    repeat (2) begin
      @(posedge clk); #1;
      chk("wdata_holdoff", 64'(wdata_ready), 64'(0));
    end
    do_write(4'h8, 16'd3, 8'd0, 1, 32'h0000_0077, RespOkay, 1'b1);
    do_read(4'h8, 16'd3, 8'd0, -1, 1'b0);

    // rdata backpressure mid-burst.
    do_read(4'h9, 16'd12, 8'd3, 1, 1'b0);

    // Collision: read load of addr 4 in the same cycle as a write to addr 4.
    do_write(4'h1, 16'd4, 8'd0, 1, 32'h0000_0044, RespOkay, 1'b0);
    waddr_req.id = 4'h2;
    waddr_req.addr = 16'd4;
    waddr_req.burst_len = 8'd0;
    waddr_valid = 1'b1;
    n = 0;
    while (!waddr_ready && n < 50) begin @(posedge clk); #1; n++; end
    chk("col_waddr_ready", 64'(waddr_ready), 64'(1));
    @(posedge clk); #1;
    waddr_valid = 1'b0;
    wdata_req.data = 32'h55;
    wdata_req.last = 1'b1;
    wdata_valid = 1'b1;
    raddr_req.id = 4'h6;
    raddr_req.addr = 16'd4;
    raddr_req.burst_len = 8'd0;
    raddr_valid = 1'b1;
    rdata_ready = 1'b0;
    chk("col_wdata_ready", 64'(wdata_ready), 64'(1));
    chk("col_raddr_ready", 64'(raddr_ready), 64'(1));
    @(posedge clk); #1;
    wdata_valid = 1'b0;
    raddr_valid = 1'b0;
    chk("col_rdata_valid", 64'(rdata_valid), 64'(1));
    chk("col_rdata_old", 64'(rdata.data), 64'(32'h44));
    chk("col_wresp_valid", 64'(wresp_valid), 64'(1));
    chk("col_wresp_rsp", 64'(wresp.rsp), 64'(RespOkay));
    rdata_ready = 1'b1;
    wresp_ready = 1'b1;
    @(posedge clk); #1;
    rdata_ready = 1'b0;
    wresp_ready = 1'b0;
    exp_mem[4] = 32'h55;
    chk("col_rdata_done", 64'(rdata_valid), 64'(0));
    chk("col_wresp_done", 64'(wresp_valid), 64'(0));
    do_read(4'h6, 16'd4, 8'd0, -1, 1'b0);

    // Reset in the middle of a read burst and a write burst.
    raddr_req.id = 4'h1;
    raddr_req.addr = 16'd0;
    raddr_req.burst_len = 8'd3;
    raddr_valid = 1'b1;
    rdata_ready = 1'b0;
    @(posedge clk); #1;
    raddr_valid = 1'b0;
    chk("mid_rdata_valid", 64'(rdata_valid), 64'(1));
    waddr_req.id = 4'h5;
    waddr_req.addr = 16'd1;
    waddr_req.burst_len = 8'd3;
    waddr_valid = 1'b1;
    @(posedge clk); #1;
    waddr_valid = 1'b0;
    wdata_req.data = 32'hDEAD;
    wdata_req.last = 1'b0;
    wdata_valid = 1'b1;
    chk("mid_wdata_ready", 64'(wdata_ready), 64'(1));
    @(posedge clk); #1;
    wdata_valid = 1'b0;
    wresp_ready = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("rst2_rdata_valid", 64'(rdata_valid), 64'(0));
    chk("rst2_wresp_valid", 64'(wresp_valid), 64'(0));
    chk("rst2_raddr_ready", 64'(raddr_ready), 64'(1));
    chk("rst2_waddr_ready", 64'(waddr_ready), 64'(1));
    chk("rst2_wdata_ready", 64'(wdata_ready), 64'(0));
    chk("rst2_rdata", 64'(rdata), 64'(0));
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 16; i++) exp_mem[i] = '0;
    repeat (5) begin
      @(posedge clk); #1;
      chk("post_rst_wresp", 64'(wresp_valid), 64'(0));
      chk("post_rst_wdata_ready", 64'(wdata_ready), 64'(0));
    end
    wresp_ready = 1'b0;
    do_read(4'h1, 16'd0, 8'd15, -1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
